// File: rtl/dbus_tcm_responder.sv
// Tightly-coupled data memory responder: 64-bit words plus a capability tag,
// fixed-latency in-order responses, and a bounded number of outstanding grants.
module dbus_tcm_responder #(
  parameter int unsigned DataW    = 65,
  parameter int unsigned NWords   = 1024,
  parameter logic [31:0] BaseAddr = 32'h8000_0000,
  parameter int unsigned RespLat  = 1,
  parameter int unsigned MaxOut   = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic             data_we_i,
  input  logic [7:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [DataW-1:0] data_wdata_i,
  output logic             data_rvalid_o,
  output logic [DataW-1:0] data_rdata_o,
  output logic             data_err_o,
  input  logic             stall_i
);

  localparam int unsigned IdxW    = $clog2(NWords);
  localparam int unsigned CntW    = 2;
  localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(8 * NWords);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [DataW-1:0] rdata;
  } resp_t;

  logic [63:0]     mem [NWords];
  logic [NWords-1:0] tags;
  resp_t           pipe [RespLat];
  resp_t           new_resp_c;
  logic [CntW-1:0] outstanding;

  logic            retire_c;
  logic            acc_c;
  logic            addr_err_c;
  logic            wr_c;
  logic [31:0]     offset_c;
  logic [IdxW-1:0] idx_c;

  assign retire_c   = pipe[RespLat-1].valid;
  assign data_gnt_o = data_req_i & ~stall_i &
                      ((outstanding < CntW'(MaxOut)) | retire_c);
  assign acc_c      = data_req_i & data_gnt_o;

  assign offset_c   = data_addr_i - BaseAddr;
  assign idx_c      = IdxW'(offset_c >> 3);
  assign addr_err_c = (data_addr_i[2:0] != 3'b000) | (data_addr_i < BaseAddr) |
                      ({1'b0, data_addr_i} >= EndAddr);
  // be == 0 writes are acknowledged but touch neither data nor tag.
  assign wr_c       = acc_c & ~addr_err_c & data_we_i & (data_be_i != 8'h00);

  // Response for the request accepted this cycle; reads sample the array at the grant edge.
  always_comb begin
    new_resp_c       = '0;
    new_resp_c.valid = acc_c;
    new_resp_c.err   = acc_c & addr_err_c;
    if (acc_c && !addr_err_c && !data_we_i) begin
      new_resp_c.rdata = DataW'({tags[idx_c], mem[idx_c]});
    end
  end

  // Word data has no reset so it survives reset assertion.
  always_ff @(posedge clk_i) begin
    if (wr_c) begin
      for (int i = 0; i < 8; i++) begin
        if (data_be_i[i]) begin
          mem[idx_c][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Tag survives only full-word writes; any partial write strips it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tags <= '0;
    end else if (wr_c) begin
      tags[idx_c] <= (data_be_i == 8'hFF) ? data_wdata_i[DataW-1] : 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RespLat; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= new_resp_c;
      for (int i = 1; i < RespLat; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({acc_c, retire_c})
        2'b10:   outstanding <= outstanding + CntW'(1);
        2'b01:   outstanding <= outstanding - CntW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign data_rvalid_o = pipe[RespLat-1].valid;
  assign data_err_o    = pipe[RespLat-1].err;
  assign data_rdata_o  = pipe[RespLat-1].rdata;

endmodule

// File: tb/tb_dbus_tcm_responder.sv
// Directed and randomized checks of dbus_tcm_responder against a transaction-level
// model: an array of words/tags plus a queue of expected responses with due cycles.
module tb_dbus_tcm_responder;

  localparam int unsigned DataW    = 65;
  localparam int unsigned NWords   = 64;
  localparam logic [31:0] BaseAddr = 32'h8000_0000;
  localparam int unsigned RespLat  = 3;
  localparam int unsigned MaxOut   = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             data_req_i = 1'b0;
  logic             data_gnt_o;
  logic             data_we_i = 1'b0;
  logic [7:0]       data_be_i = '0;
  logic [31:0]      data_addr_i = '0;
  logic [DataW-1:0] data_wdata_i = '0;
  logic             data_rvalid_o;
  logic [DataW-1:0] data_rdata_o;
  logic             data_err_o;
  logic             stall_i = 1'b0;

  always #5 clk_i = ~clk_i;

  dbus_tcm_responder #(
    .DataW(DataW), .NWords(NWords), .BaseAddr(BaseAddr),
    .RespLat(RespLat), .MaxOut(MaxOut)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o), .stall_i(stall_i)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [64:0] rdata;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  exp_t        expq[$];
  logic [63:0] mdl_mem [NWords];
  logic        mdl_tag [NWords];
  logic        last_gnt = 1'b0;
  logic        log_gnt = 1'b0;
  logic        gnt_log[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    logic [63:0] a64;
    a64 = {32'b0, a};
    return (a[2:0] != 3'b000) || (a < BaseAddr) ||
           (a64 >= 64'(BaseAddr) + 64'(8 * NWords));
  endfunction

  // One bus cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic req, input logic we, input logic [7:0] be,
                      input logic [31:0] addr, input logic [64:0] wdata, input logic stall);
    logic exp_gnt, exp_rv;
    exp_t e;
    int   idx;
    @(negedge clk_i);
    data_req_i = req; data_we_i = we; data_be_i = be;
    data_addr_i = addr; data_wdata_i = wdata; stall_i = stall;
    #1;
    exp_rv  = (expq.size() > 0) && (expq[0].due == cyc);
    exp_gnt = req && !stall && ((expq.size() < MaxOut) || exp_rv);
    chk("gnt", 65'(data_gnt_o), 65'(exp_gnt));
    chk("rvalid", 65'(data_rvalid_o), 65'(exp_rv));
    if (exp_rv) begin
      e = expq.pop_front();
      chk("err", 65'(data_err_o), 65'(e.err));
      chk("rdata", data_rdata_o, e.rdata);
    end
    last_gnt = data_gnt_o;
    if (log_gnt) gnt_log.push_back(data_gnt_o);
    if (exp_gnt) begin
      e.due   = cyc + RespLat;
      e.err   = addr_bad(addr);
      e.rdata = '0;
      if (!e.err) begin
        idx = int'((addr - BaseAddr) >> 3);
        if (!we) begin
          e.rdata = {mdl_tag[idx], mdl_mem[idx]};
        end else if (be != 8'h00) begin
          for (int b = 0; b < 8; b++)
            if (be[b]) mdl_mem[idx][8*b +: 8] = wdata[8*b +: 8];
          mdl_tag[idx] = (be == 8'hFF) ? wdata[64] : 1'b0;
        end
      end
      expq.push_back(e);
    end
    @(posedge clk_i);
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 32'h0, 65'h0, 1'b0);
  endtask

  // Hold the request until granted, optionally with random grant stalls.
  task automatic issue(input logic we, input logic [7:0] be, input logic [31:0] addr,
                       input logic [64:0] wdata, input logic rand_stall);
    int n = 0;
    do begin
      step(1'b1, we, be, addr, wdata, rand_stall && ($urandom_range(0, 3) == 0));
      n++;
    end while (!last_gnt && n < 50);
    chk("issue_grant", 65'(last_gnt), 65'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 20) begin
      idle();
      n++;
    end
    chk("drain", 65'(expq.size()), 65'(0));
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk_i);
    rst_ni = 1'b0; data_req_i = 1'b0; stall_i = 1'b0;
    expq.delete();
    for (int i = 0; i < NWords; i++) mdl_tag[i] = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) @(negedge clk_i);
      #1;
      chk("rst_rvalid", 65'(data_rvalid_o), 65'(0));
      chk("rst_err", 65'(data_err_o), 65'(0));
      chk("rst_rdata", data_rdata_o, 65'(0));
      chk("rst_gnt", 65'(data_gnt_o), 65'(0));
      @(posedge clk_i);
      cyc++;
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0: return BaseAddr + 32'd4;
      1: return BaseAddr - 32'd8;
      2: return BaseAddr + 32'(8 * NWords);
      3: return BaseAddr + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(1, 7));
      default: return BaseAddr + 32'(8 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    do_reset(3);

    // Full-word write then read back with tag.
    issue(1'b1, 8'hFF, 32'h8000_0010, {1'b1, 64'h1122_3344_5566_7788}, 1'b0);
    issue(1'b0, 8'hFF, 32'h8000_0010, 65'h0, 1'b0);
    drain();

    // Partial write strips the tag and merges one byte.
    issue(1'b1, 8'hFF, 32'h8000_0018, {1'b1, 64'h0102_0304_0506_0708}, 1'b0);
    issue(1'b1, 8'h01, 32'h8000_0018, 65'h0AA, 1'b0);
    issue(1'b0, 8'h00, 32'h8000_0018, 65'h0, 1'b0);
    drain();

    // Error responses; bad writes must not disturb memory.
    issue(1'b0, 8'hFF, 32'h8000_0004, 65'h0, 1'b0);
    issue(1'b0, 8'hFF, BaseAddr + 32'(8 * NWords), 65'h0, 1'b0);
    issue(1'b1, 8'hFF, 32'h8000_0014, {1'b0, 64'hDEAD_BEEF_DEAD_BEEF}, 1'b0);
    issue(1'b1, 8'hFF, 32'h7FFF_FFF8, {1'b0, 64'hDEAD_BEEF_DEAD_BEEF}, 1'b0);
    issue(1'b1, 8'h00, 32'h8000_0010, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0);
    issue(1'b0, 8'hFF, 32'h8000_0010, 65'h0, 1'b0);
    drain();

    // Initialise the working set (words 0..15) except the two already written.
    for (int w = 0; w < 16; w++)
      if (w != 2 && w != 3)
        issue(1'b1, 8'hFF, BaseAddr + 32'(8 * w),
              {1'($urandom), 32'($urandom), 32'($urandom)}, 1'b0);
    drain();

    // Six back-to-back reads with req held high: grant pattern limited by MaxOut.
    log_gnt = 1'b1;
    for (int r = 0; r < 6; r++) issue(1'b0, 8'hFF, BaseAddr + 32'(8 * r), 65'h0, 1'b0);
    log_gnt = 1'b0;
    pat = {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3], gnt_log[4], gnt_log[5]};
    chk("gnt_pattern", 65'(pat), 65'(6'b110110));
    drain();

    // Stall holds off the grant for four cycles.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 1'b0, 8'hFF, BaseAddr, 65'h0, 1'b1);
      chk("stall_gnt", 65'(last_gnt), 65'(0));
    end
    step(1'b1, 1'b0, 8'hFF, BaseAddr, 65'h0, 1'b0);
    chk("stall_release_gnt", 65'(last_gnt), 65'(1));
    drain();

    // Randomized mix of reads, writes, errors, stalls and idle gaps.
    for (int t = 0; t < 300; t++) begin
      logic [7:0] be;
      be = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      issue(1'($urandom), be, rand_addr(),
            {1'($urandom), 32'($urandom), 32'($urandom)}, 1'b1);
      if ($urandom_range(0, 4) == 0) idle();
    end
    drain();

    // Reset one cycle after a read grant: no late response, tags cleared, data kept.
    issue(1'b1, 8'hFF, BaseAddr + 32'd24, {1'b1, 64'hCAFE_F00D_1234_5678}, 1'b0);
    drain();
    issue(1'b0, 8'hFF, BaseAddr + 32'd24, 65'h0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 6; i++) idle();
    issue(1'b0, 8'hFF, BaseAddr + 32'd24, 65'h0, 1'b0);
    issue(1'b0, 8'hFF, BaseAddr + 32'd8, 65'h0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
